// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch sequencer.
// RESET_PC, FSM state encoding and the IF/ID bundle.
package fetch_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fstate_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } if_id_t;

  function automatic logic [31:0] align_w(
    input logic [31:0] a
  );
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_seq_if.sv
// Instruction-memory request/response bundle.
// master = fetch sequencer, slave = instruction memory.
interface fetch_seq_if;

  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ready_i,
    input  imem_rvalid_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ready_i,
    output imem_rvalid_i,
    output imem_rdata_i
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry instruction/pc holder, filled when a
// response lands while the hazard unit stalls IF.
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc
);

  logic [31:0] r_instr;
  logic [31:0] r_pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_seq.sv
// IF sequencer: PC, single-outstanding imem fetch, redirects.
// `define DELAY_SLOT_EN keeps the post-branch instruction alive.
module fetch_seq #(
  parameter logic [31:0] RESET_PC = fetch_pkg::RESET_PC,
  parameter int          AW       = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall_i,
  input  logic          redir_valid_i,
  input  logic [AW-1:0] redir_target_i,
  fetch_seq_if.master   imem,
  output logic          if_valid_o,
  output logic [AW-1:0] if_instr_o,
  output logic [AW-1:0] if_pc_o,
  output logic [AW-1:0] if_pc_plus4_o,
  output logic          flush_o
);
  import fetch_pkg::*;

  fstate_e     r_state;
  logic [31:0] r_pc;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_pend_tgt;
  logic        r_pend;
  logic        r_flush;
  if_id_t      r_ifid;

  logic        w_redir;
  logic        w_rsp;
  logic        w_take;
  logic        w_eff_pend;
  logic        w_kill;
  logic [31:0] w_tgt;
  logic [31:0] w_eff_tgt;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic [31:0] w_buf_instr;
  logic [31:0] w_buf_pc;

  assign w_redir    = redir_valid_i & ~stall_i;
  assign w_tgt      = align_w(redir_target_i);
  assign w_rsp      = (r_state == WAIT) & imem.imem_rvalid_i;
  assign w_take     = ~stall_i & (w_rsp | (r_state == HOLD));
  assign w_eff_pend = r_pend | w_redir;
  assign w_eff_tgt  = w_redir ? w_tgt : r_pend_tgt;

  assign w_instr = (r_state == HOLD) ? w_buf_instr
                                     : imem.imem_rdata_i;
  assign w_pc    = (r_state == HOLD) ? w_buf_pc
                                     : r_fetch_pc;

`ifdef DELAY_SLOT_EN
  assign w_kill = 1'b0;
`else
  // a pending redirect means this word is on the wrong path
  assign w_kill = w_eff_pend;
`endif

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_rsp & stall_i),
    .i_instr (imem.imem_rdata_i),
    .i_pc    (r_fetch_pc),
    .o_instr (w_buf_instr),
    .o_pc    (w_buf_pc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= REQ;
      r_pc       <= RESET_PC;
      r_fetch_pc <= '0;
      r_pend     <= 1'b0;
      r_pend_tgt <= '0;
      r_ifid     <= '0;
      r_flush    <= 1'b0;
    end else begin
      r_flush <= 1'b0;
      if (w_redir) begin
        r_pend     <= 1'b1;
        r_pend_tgt <= w_tgt;
      end
      case (r_state)
        REQ: begin
          if (imem.imem_ready_i) begin
            r_fetch_pc <= r_pc;
            r_state    <= WAIT;
          end
        end
        WAIT: begin
          if (imem.imem_rvalid_i)
            r_state <= stall_i ? HOLD : REQ;
        end
        HOLD: begin
          if (!stall_i) r_state <= REQ;
        end
        default: r_state <= REQ;
      endcase
      // consuming an instruction also retires any pending redirect
      if (w_take) begin
        r_ifid <= '{
          valid:    ~w_kill,
          instr:    w_instr,
          pc:       w_pc,
          pc_plus4: w_pc + 32'd4
        };
        r_flush <= w_kill;
        r_pc    <= w_eff_pend ? w_eff_tgt
                              : w_pc + 32'd4;
        r_pend  <= 1'b0;
      end
    end
  end

  assign imem.imem_req_o  = (r_state == REQ) & rst_n;
  assign imem.imem_addr_o = r_pc;

  assign if_valid_o    = r_ifid.valid;
  assign if_instr_o    = r_ifid.instr;
  assign if_pc_o       = r_ifid.pc;
  assign if_pc_plus4_o = r_ifid.pc_plus4;
  assign flush_o       = r_flush;

endmodule

// File: tb/tb_fetch_seq.sv
// Bench for fetch_seq: directed vector table, then random
// traffic against a transaction-level fetch model.
module tb_fetch_seq;
  import fetch_pkg::*;

`ifdef DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0;
  logic        redir_valid_i = 1'b0;
  logic [31:0] redir_target_i = '0;
  logic        if_valid_o;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_pc_plus4_o;
  logic        flush_o;

  fetch_seq_if bus ();

  fetch_seq dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_i        (stall_i),
    .redir_valid_i  (redir_valid_i),
    .redir_target_i (redir_target_i),
    .imem           (bus.master),
    .if_valid_o     (if_valid_o),
    .if_instr_o     (if_instr_o),
    .if_pc_o        (if_pc_o),
    .if_pc_plus4_o  (if_pc_plus4_o),
    .flush_o        (flush_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [31:0] ins_of(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input bit er,
                           input logic [31:0] ea, input bit ev,
                           input logic [31:0] epc, input bit ef);
    chk({tag, " req"}, 32'(bus.imem_req_o), 32'(er));
    if (er) chk({tag, " addr"}, bus.imem_addr_o, ea);
    chk({tag, " valid"}, 32'(if_valid_o), 32'(ev));
    if (ev) begin
      chk({tag, " pc"}, if_pc_o, epc);
      chk({tag, " instr"}, if_instr_o, ins_of(epc));
      chk({tag, " pc4"}, if_pc_plus4_o, epc + 32'd4);
    end
    chk({tag, " flush"}, 32'(flush_o), 32'(ef));
  endtask

  typedef struct {
    bit          rst;
    bit          stall;
    bit          redir;
    logic [31:0] tgt;
    bit          ready;
    bit          rv;
    logic [31:0] rpc;
    bit          er;
    logic [31:0] ea;
    bit          ev;
    logic [31:0] epc;
    bit          ef;
  } vec_t;

  vec_t vq[$];

  function automatic void add(bit rst, bit stall, bit redir,
                              logic [31:0] tgt, bit ready, bit rv,
                              logic [31:0] rpc, bit er,
                              logic [31:0] ea, bit ev,
                              logic [31:0] epc, bit ef);
    vec_t v;
    v = '{rst, stall, redir, tgt, ready, rv, rpc,
          er, ea, ev, epc, ef};
    vq.push_back(v);
  endfunction

  task automatic apply(input int idx, input vec_t v);
    rst_n              = v.rst;
    stall_i            = v.stall;
    redir_valid_i      = v.redir;
    redir_target_i     = v.tgt;
    bus.imem_ready_i   = v.ready;
    bus.imem_rvalid_i  = v.rv;
    bus.imem_rdata_i   = ins_of(v.rpc);
    @(posedge clk);
    @(negedge clk);
    check_out($sformatf("vec%0d", idx), v.er, v.ea,
              v.ev, v.epc, v.ef);
  endtask

  // transaction-level model of the fetch stream
  bit          m_out, m_have, m_pend, m_v, m_fl;
  logic [31:0] m_npc, m_fpc, m_ptgt, m_pc;

  task automatic model_reset();
    m_out = 0; m_have = 0; m_pend = 0; m_v = 0; m_fl = 0;
    m_npc = RESET_PC; m_fpc = '0; m_ptgt = '0; m_pc = '0;
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_fl = 0;
    if (redir_valid_i && !stall_i) begin
      m_pend = 1;
      m_ptgt = redir_target_i & 32'hFFFF_FFFC;
    end
    if (!m_out) begin
      if (bus.imem_ready_i) begin
        m_out = 1;
        m_fpc = m_npc;
      end
    end else begin
      if (bus.imem_rvalid_i) m_have = 1;
      if (m_have && !stall_i) begin
        m_v   = DS || !m_pend;
        m_fl  = !DS && m_pend;
        m_pc  = m_fpc;
        m_npc = m_pend ? m_ptgt : m_fpc + 32'd4;
        m_pend = 0;
        m_out  = 0;
        m_have = 0;
      end
    end
  endtask

  bit          mb;
  int          mc;
  logic [31:0] ma;
  bit          s_req;
  logic [31:0] s_addr;

  initial begin
    bus.imem_ready_i  = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = '0;
    model_reset();
    mb = 0; mc = 0; ma = '0;

    add(1,0,0,0,          1,0,0,          0,0,          0,0,0);
    add(1,0,0,0,          1,1,32'h3000,   1,32'h3004,   1,32'h3000,0);
    add(1,0,0,0,          1,0,0,          0,0,          1,32'h3000,0);
    add(1,1,0,0,          1,1,32'h3004,   0,0,          1,32'h3000,0);
    add(1,1,0,0,          1,0,0,          0,0,          1,32'h3000,0);
    add(1,1,0,0,          1,0,0,          0,0,          1,32'h3000,0);
    add(1,0,0,0,          1,0,0,          1,32'h3008,   1,32'h3004,0);
    add(1,0,0,0,          1,0,0,          0,0,          1,32'h3004,0);
    add(1,0,1,32'h3101,   1,0,0,          0,0,          1,32'h3004,0);
    add(1,0,0,0,          1,1,32'h3008,   1,32'h3100,   DS,32'h3008,!DS);
    add(1,0,0,0,          0,0,0,          1,32'h3100,   DS,32'h3008,0);
    add(1,0,1,32'h3200,   0,0,0,          1,32'h3100,   DS,32'h3008,0);
    add(1,0,0,0,          0,0,0,          1,32'h3100,   DS,32'h3008,0);
    add(1,0,0,0,          0,0,0,          1,32'h3100,   DS,32'h3008,0);
    add(1,0,0,0,          1,0,0,          0,0,          DS,32'h3008,0);
    add(1,0,0,0,          1,1,32'h3100,   1,32'h3200,   DS,32'h3100,!DS);
    add(1,0,0,0,          1,0,0,          0,0,          DS,32'h3100,0);
    add(1,0,0,0,          1,1,32'h3200,   1,32'h3204,   1,32'h3200,0);
    add(1,0,0,0,          1,0,0,          0,0,          1,32'h3200,0);
    add(1,0,1,32'h3300,   1,0,0,          0,0,          1,32'h3200,0);
    add(0,0,0,0,          0,0,0,          0,0,          0,0,0);
    add(1,0,0,0,          0,0,0,          1,32'h3000,   0,0,0);
    add(1,0,0,0,          1,0,0,          0,0,          0,0,0);
    add(1,0,0,0,          1,1,32'h3000,   1,32'h3004,   1,32'h3000,0);
    add(1,0,0,0,          1,0,0,          0,0,          1,32'h3000,0);
    add(1,0,1,32'hFFFF_FFFC,1,1,32'h3004, 1,32'hFFFF_FFFC,DS,32'h3004,!DS);
    add(1,0,0,0,          1,0,0,          0,0,          DS,32'h3004,0);
    add(1,0,0,0,          1,1,32'hFFFF_FFFC,1,32'h0,    1,32'hFFFF_FFFC,0);
    add(1,0,0,0,          1,0,0,          0,0,          1,32'hFFFF_FFFC,0);
    add(1,1,1,32'h3400,   1,0,0,          0,0,          1,32'hFFFF_FFFC,0);
    add(1,0,0,0,          1,1,32'h0,      1,32'h4,      1,32'h0,0);

    repeat (2) @(negedge clk);
    check_out("reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    #1;
    check_out("post_reset", 1, RESET_PC, 0, 0, 0);
    foreach (vq[i]) apply(i, vq[i]);

    rst_n = 1'b0;
    stall_i = 0; redir_valid_i = 0;
    bus.imem_ready_i = 0; bus.imem_rvalid_i = 0;
    @(posedge clk);
    model_reset();
    mb = 0;
    @(negedge clk);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      check_out("rnd", !m_out && rst_n, m_npc, m_v, m_pc, m_fl);
      rst_n          = ($urandom_range(0, 149) != 0);
      stall_i        = ($urandom_range(0, 3) == 0);
      redir_valid_i  = ($urandom_range(0, 9) == 0);
      redir_target_i = ($urandom_range(0, 3) == 0)
                       ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                       : 32'($urandom);
      bus.imem_ready_i = ($urandom_range(0, 9) < 7);
      if (mb && mc == 0) begin
        bus.imem_rvalid_i = 1'b1;
        bus.imem_rdata_i  = ins_of(ma);
      end else begin
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = 32'($urandom);
        if (mb) mc--;
      end
      #1;
      s_req  = bus.imem_req_o;
      s_addr = bus.imem_addr_o;
      @(posedge clk);
      model_step();
      if (!rst_n) begin
        mb = 0;
      end else begin
        if (bus.imem_rvalid_i) mb = 0;
        if (s_req && bus.imem_ready_i) begin
          mb = 1;
          ma = s_addr;
          mc = $urandom_range(0, 2);
        end
      end
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
- Instruction-fetch sequencer for the pipelined MIPS core.
- Owns the architectural PC register and issues single-outstanding requests to instruction memory.
- Applies redirects (taken branch/jump targets computed by the next-PC logic in ID) and honours hazard-unit stalls.
- Drives the IF/ID register fields (valid, instr, pc, pc+4).

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- AW, 32, address/data width; only 32 supported.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- stall_i  in  1  hazard unit: hold IF/ID outputs, do not consume a new instruction.
- redir_valid_i  in  1  ID stage: control transfer taken this cycle; sampled only when stall_i=0.
- redir_target_i  in  32  next-PC target accompanying redir_valid_i.
- imem_req_o  out  1  fetch request valid.
- imem_addr_o  out  32  fetch address, word aligned.
- imem_ready_i  in  1  memory accepts request (handshake on req&ready).
- imem_rvalid_i  in  1  response valid, at least 1 cycle after accept.
- imem_rdata_i  in  32  instruction word.
- if_valid_o  out  1  IF/ID holds a live instruction.
- if_instr_o  out  32  IF/ID instruction.
- if_pc_o  out  32  IF/ID instruction address.
- if_pc_plus4_o  out  32  if_pc_o+4, to next-PC logic.
- flush_o  out  1  one-cycle pulse: wrong-path instruction killed.

Behaviour:
- Reset (rst_n=0 at clk edge): pc=RESET_PC, state=REQ, pend_valid=0, if_valid_o=0, if_instr_o=0, if_pc_o=0, if_pc_plus4_o=0, flush_o=0, buffer empty. imem_req_o is 0 during the reset cycle and 1 the first cycle after.
- imem must be reset by the same rst_n. No response survives reset; reset mid-fetch abandons the transaction.
- FSM states:
  - REQ: imem_req_o=1, imem_addr_o=pc. Address stays stable until req&ready. On accept -> WAIT and latch fetch_pc=pc.
  - WAIT: imem_req_o=0. On rvalid: if stall_i=0, load IF/ID and go to REQ; if stall_i=1, capture into the one-entry buffer and go to HOLD.
  - HOLD: imem_req_o=0. On the first cycle with stall_i=0, load IF/ID from the buffer and go to REQ.
- PC update: on each consumed instruction, pc=fetch_pc+4 unless a redirect is pending (see below). Arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- Best-case timing (ready=1, rvalid 1 cycle after accept): accept at n, rvalid at n+1, if_valid_o=1 at n+2. Throughput is one instruction per 2 cycles.
- Stall with no fetch completing: IF/ID outputs hold value and the FSM holds state. A REQ in progress may still complete its handshake.
- Redirect (redir_valid_i & !stall_i):
  - Target is captured into pend_target, pend_valid=1.
  - The in-flight or buffered instruction (the one after the branch) is discarded. When it completes, IF/ID loads if_valid_o=0 and flush_o pulses the cycle the kill takes effect.
  - The next REQ uses pend_target, then clears pend_valid.
  - Redirect in REQ before accept: the request completes at the old address and its response is discarded.
  - Redirect in the same cycle as rvalid: that response is discarded.
  - A second redirect while pend_valid=1 overwrites pend_target, last wins.
- redir_target_i[1:0] != 0: low bits are forced to 0.
- Stall and redirect in the same cycle: the redirect is ignored; ID must re-present it.

Optional Feature:
- DELAY_SLOT_EN
  - Defined: MIPS branch delay slot. The instruction fetched immediately after the branch is delivered normally (never killed, flush_o never asserts). pend_target is applied to the following fetch.
  - Undefined: kill behaviour as described in Behaviour.

Decomposition:
- Package fetch_pkg:
  - RESET_PC constant.
  - State encoding: REQ=2'd0, WAIT=2'd1, HOLD=2'd2.
  - IF/ID bundle typedef {valid, instr, pc, pc_plus4}.
- Sub-module fetch_skid_buf: one-entry instruction/pc holding buffer used in HOLD.
- FSM, pc and pending-redirect registers live in the top module.

Test Plan:
- Reset then free-run, ready=1, 1-cycle rvalid -> addresses 0x3000, 0x3004, 0x3008; if_valid_o first high 2 cycles after the first accept; if_pc_plus4_o=0x3004 with if_pc_o=0x3000.
- stall_i=1 for 3 cycles while rvalid arrives for 0x3004 -> IF/ID holds 0x3000, no new req. Release -> IF/ID=0x3004 next cycle, then req 0x3008.
- Redirect to 0x3100 while 0x3008 is in WAIT (no DELAY_SLOT_EN) -> 0x3008 response dropped, if_valid_o=0, flush_o one pulse, next req addr 0x3100.
- Same as the previous case with DELAY_SLOT_EN -> 0x3008 delivered valid, flush_o stays 0, next req 0x3100.
- imem_ready_i=0 for 4 cycles -> req and addr 0x3000 stable throughout. Redirect during this window -> old accepted, dropped, then 0x3100 fetched.
- rst_n=0 mid-WAIT -> next cycle if_valid_o=0, pend cleared; first request after reset is 0x3000.
